// File: rtl/mux_n1_reg.sv
// N-channel, WIDTH-bit registered multiplexer with valid/ready on every channel and the output.
// Channels are granted by a latched select (fixed mode) or round-robin over valid channels.
module mux_n1_reg #(
    parameter int WIDTH = 1,
    parameter int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    inClk,
    input  logic                    inRst,
    input  logic [N_CH*WIDTH-1:0]   inData,
    input  logic [N_CH-1:0]         inValid,
    output logic [N_CH-1:0]         outReady,
    input  logic                    inMode,
    input  logic [SEL_W-1:0]        inSel,
    input  logic                    inSelLoad,
    output logic [WIDTH-1:0]        outData,
    output logic                    outValid,
    input  logic                    inReady,
    output logic [SEL_W-1:0]        outChan,
    output logic                    outSelErr
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   chan_q, chan_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   ch_data [N_CH];
    logic               may_load;
    logic               grant;
    logic [SEL_W-1:0]   grant_ch;
    logic               rr_found;
    logic [SEL_W-1:0]   rr_ch;
    logic [SEL_W:0]     rr_sum;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ch_data[c] = inData[c*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rr_found = 1'b0;
        rr_ch    = '0;
        rr_sum   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_sum = {1'b0, last_q} + (SEL_W+1)'(i);
            if (rr_sum >= (SEL_W+1)'(N_CH)) begin
                rr_sum = rr_sum - (SEL_W+1)'(N_CH);
            end
            if (!rr_found && inValid[rr_sum[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_ch    = rr_sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        may_load = (state_q == ST_EMPTY) || inReady;
        grant_ch = inMode ? rr_ch : sel_q;
        grant    = !inRst && may_load && (inMode ? rr_found : inValid[sel_q]);
        outReady = '0;
        if (grant) begin
            outReady[grant_ch] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        chan_d    = chan_q;
        sel_d     = sel_q;
        last_d    = last_q;
        sel_err_d = 1'b0;

        if (grant) begin
            state_d = ST_FULL;
            data_d  = ch_data[grant_ch];
            chan_d  = grant_ch;
            if (inMode) begin
                last_d = grant_ch;
            end
        end else if (state_q == ST_FULL && inReady) begin
            state_d = ST_EMPTY;
        end

        // Out-of-range loads leave the select untouched and flag a one-cycle error.
        if (inSelLoad) begin
            if ({1'b0, inSel} < (SEL_W+1)'(N_CH)) begin
                sel_d = inSel;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge inClk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (inRst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            chan_q    <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_CH - 1);
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign outData   = data_q;
    assign outValid  = (state_q == ST_FULL);
    assign outChan   = chan_q;
    assign outSelErr = sel_err_q;

endmodule
